// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider.
// Holds the div_op encodings, the FSM state encoding, the iteration count
// and small helpers that decode the operation.
package div_seq_pkg;

    // Operation encoding as presented on div_op
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // One quotient bit per iteration, so one iteration per result bit
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 5;

    // DIV and REM treat operands as two's complement
    function automatic logic is_signed_op(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM and REMU return the remainder, the others the quotient
    function automatic logic is_rem_op(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One combinational radix-2 restoring division step.
// Ports:
//   rem_shift_i - partial remainder already shifted left with the next
//                 dividend bit appended (WIDTH+1 bits)
//   divisor_i   - divisor magnitude
//   rem_o       - next partial remainder
//   q_bit_o     - quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_shift_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] diff_s;

    // Trial subtraction; a clear sign bit means the divisor fits
    always_comb begin
        diff_s  = rem_shift_i - {1'b0, divisor_i};
        q_bit_o = ~diff_s[WIDTH];
        if (q_bit_o) begin
            rem_o = diff_s[WIDTH-1:0];
        end else begin
            rem_o = rem_shift_i[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit integer divider (DIV, DIVU, REM, REMU).
// Ports:
//   clk, rst_n        - clock (rising edge) and async active-low reset
//   start             - request a new division (accepted only in IDLE)
//   div_op            - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend, divisor - operands, sampled with start
//   flush             - abandon any operation, return to IDLE
//   busy              - high whenever the FSM is not in IDLE
//   done              - one-cycle pulse, result valid
//   result            - quotient or remainder, held until the next DONE
// Divide-by-zero and signed overflow complete in one cycle; the normal path
// takes one operand-preparation cycle, 32 iterations, a sign fix and DONE.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       div_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    div_op_e          op_q, op_d;
    logic [WIDTH-1:0] quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prep_q, prep_d;    // first CALC cycle: take operand magnitudes
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, busy_q;

    div_op_e          op_s;
    logic             in_signed_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_q_bit_s;

    assign op_s        = div_op_e'(div_op);
    assign in_signed_s = is_signed_op(op_s);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_shift_i (rem_q[WIDTH-1:0] == rem_q ? {rem_q, quo_q[WIDTH-1]} : {rem_q, quo_q[WIDTH-1]}),
        .divisor_i   (dsr_q),
        .rem_o       (step_rem_s),
        .q_bit_o     (step_q_bit_s)
    );

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        prep_d    = prep_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        if (flush) begin
            state_d = ST_IDLE;
            prep_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_d      = op_s;
                        quo_d     = dividend;
                        dsr_d     = divisor;
                        rem_d     = ZERO_W;
                        neg_quo_d = in_signed_s && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_d = in_signed_s && dividend[WIDTH-1];
                        if (divisor == ZERO_W) begin
                            result_d = is_rem_op(op_s) ? dividend : ONES_W;
                            state_d  = ST_DONE;
                        end else if (in_signed_s && (dividend == MIN_W) && (divisor == ONES_W)) begin
                            result_d = is_rem_op(op_s) ? ZERO_W : MIN_W;
                            state_d  = ST_DONE;
                        end else begin
                            cnt_d   = CNT_LAST;
                            prep_d  = 1'b1;
                            state_d = ST_CALC;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (prep_q) begin
                        // Negation kept out of the start cycle so the capture path stays short
                        prep_d = 1'b0;
                        if (is_signed_op(op_q)) begin
                            quo_d = quo_q[WIDTH-1] ? (~quo_q + ONE_W) : quo_q;
                            dsr_d = dsr_q[WIDTH-1] ? (~dsr_q + ONE_W) : dsr_q;
                        end else begin
                            quo_d = quo_q;
                            dsr_d = dsr_q;
                        end
                    end else begin
                        quo_d = {quo_q[WIDTH-2:0], step_q_bit_s};
                        rem_d = step_rem_s;
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == {CNT_W{1'b0}}) begin
                            state_d = ST_FIX;
                        end else begin
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_FIX: begin
                    if (is_rem_op(op_q)) begin
                        result_d = neg_rem_q ? (~rem_q + ONE_W) : rem_q;
                    end else begin
                        result_d = neg_quo_q ? (~quo_q + ONE_W) : quo_q;
                    end
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_DIV;
            quo_q     <= ZERO_W;
            dsr_q     <= ZERO_W;
            rem_q     <= ZERO_W;
            cnt_q     <= {CNT_W{1'b0}};
            prep_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= ZERO_W;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            prep_q    <= prep_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= (state_d == ST_DONE);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total;
    int bad;
    logic [31:0] last_res;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          inj;
    } vec_t;

    vec_t vecs[18];

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .div_op   (div_op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    // Issue one operation, check busy/latency/result and the hold cycle after DONE.
    task automatic do_op(input int idx, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat, input int inj);
        int k;
        logic got;
        logic busy_ok;
        start = 1'b1; div_op = op; dividend = a; divisor = b;
        @(posedge clk);                      // E0
        #1;
        start = 1'b0; div_op = DIVU; dividend = 32'd50; divisor = 32'd5;
        k = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && k <= 60) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) got = 1'b1;
            else k++;
            start = (k == inj) && !got;      // a start during CALC must be ignored
        end
        start = 1'b0;
        chk("done_seen", idx, {31'd0, got}, 32'd1);
        chk("latency", idx, k, lat);
        chk("busy_during", idx, {31'd0, busy_ok}, 32'd1);
        chk("result", idx, result, exp);
        @(posedge clk);
        #1;
        chk("done_after", idx, {31'd0, done}, 32'd0);
        chk("busy_after", idx, {31'd0, busy}, 32'd0);
        chk("result_hold", idx, result, exp);
        last_res = exp;
    endtask

    initial begin
        int n;
        logic no_done;
        total = 0; bad = 0; last_res = 32'd0;
        start = 1'b0; flush = 1'b0; div_op = DIV; dividend = 32'd0; divisor = 32'd0;
        rst_n = 1'b0;

        vecs[0]  = '{DIV,  32'd100,        32'd7,          32'd14,         34, -1};
        vecs[1]  = '{REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34, -1};
        vecs[2]  = '{REMU, 32'hFFFFFFF9,   32'd2,          32'd1,          34, -1};
        vecs[3]  = '{DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   0,  -1};
        vecs[4]  = '{REM,  32'd5,          32'd0,          32'd5,          0,  -1};
        vecs[5]  = '{DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   0,  -1};
        vecs[6]  = '{REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          0,  -1};
        vecs[7]  = '{DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   34, -1};
        vecs[8]  = '{REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   34, -1};
        vecs[9]  = '{DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   34, 5};
        vecs[10] = '{REM,  32'd100,        32'hFFFFFFF9,   32'd2,          34, 20};
        vecs[11] = '{DIVU, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF,   34, -1};
        vecs[12] = '{REMU, 32'hFFFFFFFF,   32'h00000010,   32'h0000000F,   34, -1};
        vecs[13] = '{DIV,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   0,  -1};
        vecs[14] = '{REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   34, -1};
        vecs[15] = '{DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          34, -1};
        vecs[16] = '{DIV,  32'd7,          32'd100,        32'd0,          34, -1};
        vecs[17] = '{DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   34, -1};

        // Reset state
        #12;
        chk("rst_busy", 0, {31'd0, busy}, 32'd0);
        chk("rst_done", 0, {31'd0, done}, 32'd0);
        chk("rst_result", 0, result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: back-to-back operations, first accepted on the first edge out of reset
        for (int i = 0; i < 18; i++) begin
            do_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].inj);
        end

        // flush together with start in IDLE: nothing captured
        start = 1'b1; flush = 1'b1; div_op = DIVU; dividend = 32'd5; divisor = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flushstart_busy", 0, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("flushstart_done", 0, {31'd0, done}, 32'd0);
        chk("flushstart_result", 0, result, last_res);

        // flush at E0+10 with a start presented during CALC
        start = 1'b1; div_op = DIV; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);                      // E0
        #1;
        start = 1'b0;
        no_done = 1'b1;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
            start = (c == 4);
            div_op = DIVU; dividend = 32'd50; divisor = 32'd0;
        end
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);                      // E0+10
        #1;
        flush = 1'b0;
        chk("flush_busy", 0, {31'd0, busy}, 32'd0);
        chk("flush_done", 0, {31'd0, done}, 32'd0);
        chk("flush_result", 0, result, last_res);
        chk("flush_nodone_before", 0, {31'd0, no_done}, 32'd1);
        do_op(100, DIV, 32'd1000, 32'd9, 32'd111, 34, -1);

        // Reset pulse at E0+20
        start = 1'b1; div_op = DIVU; dividend = 32'd77; divisor = 32'd7;
        @(posedge clk);                      // E0
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);          // E0+20
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 0, {31'd0, busy}, 32'd0);
        chk("rstmid_done", 0, {31'd0, done}, 32'd0);
        chk("rstmid_result", 0, result, 32'd0);
        #1;
        rst_n = 1'b1;
        no_done = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
            if (busy) n++;
        end
        chk("rstmid_nodone", 0, {31'd0, no_done}, 32'd1);
        chk("rstmid_busycnt", 0, n, 0);
        do_op(200, REMU, 32'd77, 32'd10, 32'd7, 34, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
